// File: rtl/cam_pkg.sv
// Shared constants and state encoding for the camera frame-buffer controller.
package cam_pkg;

    localparam int FB_PIXELS = 76800;
    localparam int ADDR_W    = 17;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SOF  = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_SWAP_PEND = 2'd3
    } fb_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/frame_buffer_ctrl_vsync_edge_det.sv
// Start/end-of-frame pulses from a clk-synchronous vsync level.
module vsync_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_vsync,
    output logic o_sof,
    output logic o_eof
);

    logic r_vsync_d;

    // Reset to "active" so a frame already in progress at reset never looks like a fresh SOF.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vsync_d <= 1'b1;
        end else begin
            r_vsync_d <= i_vsync;
        end
    end

    assign o_sof = i_vsync & ~r_vsync_d;
    assign o_eof = ~i_vsync & r_vsync_d;

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Double-buffered camera capture controller: writes whole frames into one bank
// and swaps banks with the display during vertical blanking.
//
// state        | meaning
// ST_IDLE      | disarmed, waiting for cmd_start
// ST_WAIT_SOF  | armed, waiting for the next vsync rise
// ST_CAPTURE   | writing pixels of the current frame into wr_bank
// ST_SWAP_PEND | full frame captured, waiting for disp_vblank to swap
module frame_buffer_ctrl
    import cam_pkg::*;
#(
    parameter int FRAME_PIXELS = FB_PIXELS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic              cmd_continuous,
    input  logic              cap_vsync,
    input  logic              cap_wr_en,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic [15:0]       cap_data,
    input  logic              disp_vblank,
    output logic              fb_wr_en,
    output logic [ADDR_W:0]   fb_wr_addr,
    output logic [15:0]       fb_wr_data,
    output logic              rd_bank,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_count,
    output logic [7:0]        drop_count
);

    localparam logic [ADDR_W-1:0] PIX_LIMIT = ADDR_W'(FRAME_PIXELS);

    fb_state_t         r_state;
    fb_state_t         w_state_next;
    logic              r_continuous;
    logic              r_stop_pending;
    logic              r_wr_bank;
    logic [ADDR_W-1:0] r_pix_cnt;
    logic              r_fb_wr_en;
    logic [ADDR_W:0]   r_fb_wr_addr;
    logic [15:0]       r_fb_wr_data;
    logic              r_frame_done;
    logic [7:0]        r_frame_count;
    logic [7:0]        r_drop_count;

    logic              w_sof;
    logic              w_eof;
    logic              w_pix_ok;
    logic              w_accept;
    logic [ADDR_W:0]   w_pix_total;
    logic              w_frame_full;
    logic              w_stop_req;
    logic              w_start_ok;
    logic              w_swap;
    logic              w_drop;
    logic              w_busy;

    vsync_edge_det u_vsync_edge_det (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_vsync (cap_vsync),
        .o_sof   (w_sof),
        .o_eof   (w_eof)
    );

    assign w_pix_ok     = cap_wr_en & (cap_addr < PIX_LIMIT);
    assign w_accept     = (r_state == ST_CAPTURE) & w_pix_ok;
    // Count includes a pixel accepted on the EOF cycle itself.
    assign w_pix_total  = {1'b0, r_pix_cnt} + {{ADDR_W{1'b0}}, w_accept};
    assign w_frame_full = (w_pix_total == {1'b0, PIX_LIMIT});
    assign w_stop_req   = r_stop_pending | cmd_stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_start && !cmd_stop) w_state_next = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                if (cmd_stop)   w_state_next = ST_IDLE;
                else if (w_sof) w_state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (w_eof) begin
                    if (w_frame_full)    w_state_next = ST_SWAP_PEND;
                    else if (w_stop_req) w_state_next = ST_IDLE;
                    else                 w_state_next = ST_WAIT_SOF;
                end
            end
            ST_SWAP_PEND: begin
                // A frame starting on the swap cycle is captured straight away.
                if (disp_vblank) begin
                    if (r_continuous && !w_stop_req)
                        w_state_next = w_sof ? ST_CAPTURE : ST_WAIT_SOF;
                    else
                        w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_start_ok = 1'b0;
        w_swap     = 1'b0;
        w_drop     = 1'b0;
        w_busy     = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE:      w_start_ok = cmd_start & ~cmd_stop;
            ST_CAPTURE:   w_drop     = w_eof & ~w_frame_full;
            ST_SWAP_PEND: begin
                w_swap = disp_vblank;
                w_drop = w_sof & ~disp_vblank;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_continuous   <= 1'b0;
            r_stop_pending <= 1'b0;
            r_wr_bank      <= 1'b0;
            r_pix_cnt      <= '0;
            r_fb_wr_en     <= 1'b0;
            r_fb_wr_addr   <= '0;
            r_fb_wr_data   <= '0;
            r_frame_done   <= 1'b0;
            r_frame_count  <= 8'd0;
            r_drop_count   <= 8'd0;
        end else begin
            r_fb_wr_en   <= w_accept;
            r_frame_done <= w_swap;
            if (w_accept) begin
                r_fb_wr_addr <= {r_wr_bank, cap_addr};
                r_fb_wr_data <= cap_data;
            end
            if (w_swap) begin
                r_wr_bank     <= ~r_wr_bank;
                r_frame_count <= r_frame_count + 8'd1;
            end
            if (w_drop) r_drop_count <= sat_inc8(r_drop_count);
            if (w_start_ok) r_continuous <= cmd_continuous;
            if (w_sof)
                r_pix_cnt <= '0;
            else if (w_accept && (r_pix_cnt != '1))
                r_pix_cnt <= r_pix_cnt + 1'b1;
            if (w_state_next == ST_IDLE)
                r_stop_pending <= 1'b0;
            else if (cmd_stop && ((r_state == ST_CAPTURE) || (r_state == ST_SWAP_PEND)))
                r_stop_pending <= 1'b1;
        end
    end

    assign fb_wr_en    = r_fb_wr_en;
    assign fb_wr_addr  = r_fb_wr_addr;
    assign fb_wr_data  = r_fb_wr_data;
    assign rd_bank     = ~r_wr_bank;
    assign busy        = w_busy;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;
    assign drop_count  = r_drop_count;

endmodule

// File: doc/frame_buffer_ctrl.md
FRAME_BUFFER_CTRL -- requirements
Module: frame_buffer_ctrl

Interface
REQ-001 SHALL have port clk, in, 1: system clock; all logic on posedge.
REQ-002 SHALL have port rst, in, 1: reset, synchronous, active-high.
REQ-003 SHALL have port cmd_start, in, 1: one-cycle pulse that arms capture.
REQ-004 SHALL have port cmd_stop, in, 1: one-cycle pulse that requests end of capture.
REQ-005 SHALL have port cmd_continuous, in, 1: mode select, 1 = continuous, 0 = single-shot; sampled on an accepted cmd_start.
REQ-006 SHALL have port cap_vsync, in, 1: camera vsync already synchronized to clk; high = active frame.
REQ-007 SHALL have port cap_wr_en, in, 1: pixel-valid strobe from the capture stream (clk domain).
REQ-008 SHALL have port cap_addr, in, 17: pixel address, 0..76799.
REQ-009 SHALL have port cap_data, in, 16: RGB565 pixel.
REQ-010 SHALL have port disp_vblank, in, 1: display vertical blanking; high = swap allowed.
REQ-011 SHALL have port fb_wr_en, out, 1: frame-buffer write strobe.
REQ-012 SHALL have port fb_wr_addr, out, 18: {wr_bank, cap_addr}.
REQ-013 SHALL have port fb_wr_data, out, 16: pixel to write.
REQ-014 SHALL have port rd_bank, out, 1: bank the display reads; always the complement of wr_bank.
REQ-015 SHALL have port busy, out, 1: high whenever state is not IDLE.
REQ-016 SHALL have port frame_done, out, 1: one-cycle pulse on each bank swap.
REQ-017 SHALL have port frame_count, out, 8: count of completed swaps; wraps 255 -> 0.
REQ-018 SHALL have port drop_count, out, 8: count of discarded frames; saturates at 255.

Function
REQ-019 SHALL detect a vsync rise (SOF) and a vsync fall (EOF) from cap_vsync and its one-cycle-delayed copy.
REQ-020 SHALL implement four states with these transitions:
- IDLE: on cmd_start, go to WAIT_SOF.
- WAIT_SOF: on SOF, go to CAPTURE.
- CAPTURE: on EOF, go to SWAP_PEND.
- SWAP_PEND: on disp_vblank, swap banks.
REQ-021 SHALL NOT start capture mid-frame: arming while cap_vsync is already high waits for the next SOF.
REQ-022 SHALL, in CAPTURE only, register the write path:
- fb_wr_en = cap_wr_en, with fixed 1-cycle latency;
- fb_wr_addr and fb_wr_data registered alongside fb_wr_en.
REQ-023 SHALL suppress writes with cap_addr >= 76800; such writes are not counted as pixels.
REQ-024 SHALL count accepted pixels in a 17-bit counter that clears at each SOF.
REQ-025 SHALL, on EOF with a pixel count other than 76800, discard the frame:
- increment drop_count;
- do not swap;
- return to WAIT_SOF, or to IDLE if a stop is pending.
REQ-026 SHALL, on a swap, in one cycle:
- toggle wr_bank and rd_bank;
- pulse frame_done;
- increment frame_count.
REQ-027 SHALL go to the following state after a swap:
- WAIT_SOF if continuous and no stop is pending;
- IDLE otherwise.
REQ-028 SHALL, on an SOF during SWAP_PEND without disp_vblank, increment drop_count, write nothing, and remain in SWAP_PEND.
REQ-029 SHALL, when a swap and an SOF occur in the same cycle in continuous mode, swap and go directly to CAPTURE (the frame is not lost).
REQ-030 SHALL handle cmd_stop as follows:
- in WAIT_SOF: go to IDLE on the next cycle;
- in CAPTURE or SWAP_PEND: set stop_pending and finish the current frame first;
- in IDLE: no effect.
REQ-031 SHALL ignore cmd_start when not in IDLE; if cmd_start and cmd_stop coincide in IDLE, stop wins and the block stays IDLE.
REQ-032 SHALL clear stop_pending when the block enters IDLE.

Reset
REQ-033 SHALL, on rst, set: state IDLE; fb_wr_en, frame_done, busy, frame_count, drop_count and stop_pending all 0; wr_bank 0; rd_bank 1.
REQ-034 SHALL let reset mid-CAPTURE abort the frame with no further fb_wr_en, and the first capture after reset SHALL wait for a fresh SOF.

Structure
REQ-035 SHALL take FB_PIXELS = 76800, ADDR_W = 17, and the state encoding from the shared package cam_pkg.
REQ-036 SHALL instantiate one sub-module, vsync_edge_det, which outputs SOF/EOF pulses; the state machine, counters and write path stay in frame_buffer_ctrl.

Verification
REQ-037 Single-shot: start with mode 0, then a full 76800-pixel frame, then disp_vblank -> exactly 76800 fb_wr_en with addr[17]=0, one frame_done, rd_bank=0, frame_count=1, IDLE.
REQ-038 Continuous, 3 frames, vblank after each EOF -> fb_wr_addr[17] sequence 0,1,0; frame_count=3; drop_count=0.
REQ-039 Short frame of 76799 pixels -> no swap, drop_count=1, rd_bank unchanged, next full frame swaps normally.
REQ-040 disp_vblank held low across 2 further SOFs in SWAP_PEND -> drop_count=2, no writes during those frames; vblank then gives a single swap.
REQ-041 cmd_stop mid-CAPTURE -> frame completes, swaps, block goes IDLE; a later SOF produces no writes.
REQ-042 Arm with cap_vsync already high; then rst asserted mid-frame -> no writes in the partial frame; after reset wr_bank=0, rd_bank=1, all counters 0.
